// File: rtl/eth_status_event_counter.sv
// Multi-channel toggle-event counter: synchronises toggle-encoded events from
// foreign domains, counts them per channel and exposes a snapshot read port.
module eth_status_event_counter #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 3,
  parameter int COUNT_WIDTH = 16,
  parameter bit SATURATE    = 1'b1,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   logic_clk,
  input  logic                   logic_rst_n,
  input  logic [CHANNELS-1:0]    evt_toggle,
  output logic [CHANNELS-1:0]    evt_pulse,
  input  logic                   snap_req,
  input  logic                   snap_clear,
  output logic                   snap_valid,
  input  logic [SEL_W-1:0]       rd_sel,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic                   rd_ovf,
  output logic                   ready
);

  typedef enum logic {PRIME, RUN} state_t;

  localparam int PC_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PC_W-1:0] PRIME_LAST = PC_W'(SYNC_STAGES);

  state_t          state_q, state_d;
  logic [PC_W-1:0] prime_cnt;
  logic            run;

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [CHANNELS-1:0] edge_p;
  logic [CHANNELS-1:0] detect;

  logic [COUNT_WIDTH-1:0] live_cnt [CHANNELS];
  logic [COUNT_WIDTH-1:0] snap_cnt [CHANNELS];
  logic [CHANNELS-1:0]    live_ovf;
  logic [CHANNELS-1:0]    snap_ovf;
  logic [COUNT_WIDTH-1:0] rd_cnt_mux;
  logic                   rd_ovf_mux;

  function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] cnt);
    if (&cnt) return SATURATE ? cnt : '0;
    return cnt + 1'b1;
  endfunction

  assign run   = (state_q == RUN);
  assign ready = run;

  // Priming FSM: lets the synchroniser settle before events are trusted
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q   <= PRIME;
      prime_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == PRIME) prime_cnt <= prime_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == PRIME && prime_cnt == PRIME_LAST) state_d = RUN;
  end

  // Synchroniser chain, edge-detect flop and registered pulse
  assign detect = sync_p[SYNC_STAGES-1] ^ edge_p;

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      edge_p    <= '0;
      evt_pulse <= '0;
    end else begin
      sync_p[0] <= evt_toggle;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      edge_p    <= sync_p[SYNC_STAGES-1];
      evt_pulse <= run ? detect : '0;
    end
  end

  // Live counters and snapshot capture; a clearing capture keeps a coincident event
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        live_cnt[c] <= '0;
        snap_cnt[c] <= '0;
      end
      live_ovf   <= '0;
      snap_ovf   <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (snap_req) snap_valid <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (snap_req) begin
          snap_cnt[c] <= live_cnt[c];
          snap_ovf[c] <= live_ovf[c];
        end
        if (snap_req && snap_clear) begin
          live_cnt[c] <= COUNT_WIDTH'(evt_pulse[c]);
          live_ovf[c] <= 1'b0;
        end else if (evt_pulse[c]) begin
          live_cnt[c] <= bump(live_cnt[c]);
          if (&live_cnt[c]) live_ovf[c] <= 1'b1;
        end
      end
    end
  end

  // Read port: out-of-range selects fall through to zero
  always_comb begin
    rd_cnt_mux = '0;
    rd_ovf_mux = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_sel == SEL_W'(c)) begin
        rd_cnt_mux = snap_cnt[c];
        rd_ovf_mux = snap_ovf[c];
      end
    end
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      rd_data <= rd_cnt_mux;
      rd_ovf  <= rd_ovf_mux;
    end
  end

endmodule

// File: tb/tb_eth_status_event_counter.sv
// Directed bench: four instances (defaults, 4-bit saturating, 4-bit wrapping,
// three channels) share stimulus and are checked against hand-computed values.
module tb_eth_status_event_counter;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  tog = '0;
  logic        snap_req = 1'b0;
  logic        snap_clear = 1'b0;
  logic [1:0]  rd_sel = '0;

  logic [3:0]  p0, p1, p2;
  logic [2:0]  p3;
  logic        v0, v1, v2, v3;
  logic [15:0] rd0, rd3;
  logic [3:0]  rd1, rd2;
  logic        o0, o1, o2, o3;
  logic        r0, r1, r2, r3;

  int tests = 0;
  int fails = 0;
  int pc0 [4] = '{default: 0};

  always #5 clk = ~clk;

  eth_status_event_counter dut0 (
    .logic_clk(clk), .logic_rst_n(rst_n), .evt_toggle(tog), .evt_pulse(p0),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_valid(v0),
    .rd_sel(rd_sel), .rd_data(rd0), .rd_ovf(o0), .ready(r0));

  eth_status_event_counter #(.COUNT_WIDTH(4), .SATURATE(1'b1)) dut1 (
    .logic_clk(clk), .logic_rst_n(rst_n), .evt_toggle(tog), .evt_pulse(p1),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_valid(v1),
    .rd_sel(rd_sel), .rd_data(rd1), .rd_ovf(o1), .ready(r1));

  eth_status_event_counter #(.COUNT_WIDTH(4), .SATURATE(1'b0)) dut2 (
    .logic_clk(clk), .logic_rst_n(rst_n), .evt_toggle(tog), .evt_pulse(p2),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_valid(v2),
    .rd_sel(rd_sel), .rd_data(rd2), .rd_ovf(o2), .ready(r2));

  eth_status_event_counter #(.CHANNELS(3)) dut3 (
    .logic_clk(clk), .logic_rst_n(rst_n), .evt_toggle(tog[2:0]), .evt_pulse(p3),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_valid(v3),
    .rd_sel(rd_sel), .rd_data(rd3), .rd_ovf(o3), .ready(r3));

  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (p0[i]) pc0[i]++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_snap(input logic clr);
    snap_req   = 1'b1;
    snap_clear = clr;
    @(negedge clk);
    snap_req   = 1'b0;
    snap_clear = 1'b0;
  endtask

  task automatic rd(input logic [1:0] s);
    rd_sel = s;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!r0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, r0}, 1);
  endtask

  initial begin
    int lat;
    int base;

    tog[0] = 1'b1;
    cyc(3);
    chk("rst_ready", {31'd0, r0}, 0);
    chk("rst_valid", {31'd0, v0}, 0);
    chk("rst_rd", {16'd0, rd0}, 0);
    chk("rst_pulse", {28'd0, p0}, 0);

    rst_n = 1'b1;
    cyc(S);
    chk("prime_busy", {31'd0, r0}, 0);
    cyc(1);
    chk("prime_done", {31'd0, r0}, 1);
    cyc(5);
    chk("no_prime_evt", pc0[0], 0);
    do_snap(1'b0);
    chk("snap_valid", {31'd0, v0}, 1);
    rd(2'd0);
    chk("snap_ch0_zero", {16'd0, rd0}, 0);

    base = pc0[1];
    for (int k = 0; k < 5; k++) begin
      tog[1] = ~tog[1];
      lat = 1;
      while (!p0[1] && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("pulse_lat", lat, S + 2);
      cyc(6);
    end
    chk("pulse_cnt_ch1", pc0[1] - base, 5);
    do_snap(1'b0);
    rd(2'd1);
    chk("snap_ch1", {16'd0, rd0}, 5);
    chk("ovf_ch1", {31'd0, o0}, 0);
    chk("snap_ch1_w4", {28'd0, rd1}, 5);

    for (int k = 0; k < 20; k++) begin
      tog[2] = ~tog[2];
      cyc(3);
    end
    cyc(6);
    do_snap(1'b0);
    rd(2'd2);
    chk("sat_val", {28'd0, rd1}, 15);
    chk("sat_ovf", {31'd0, o1}, 1);
    chk("wrap_val", {28'd0, rd2}, 4);
    chk("wrap_ovf", {31'd0, o2}, 1);
    chk("wide_val", {16'd0, rd0}, 20);
    chk("wide_ovf", {31'd0, o0}, 0);
    chk("ch3_inst_val", {16'd0, rd3}, 20);
    rd(2'd3);
    chk("oob_rd", {16'd0, rd3}, 0);
    chk("oob_ovf", {31'd0, o3}, 0);

    for (int k = 0; k < 7; k++) begin
      tog[3] = ~tog[3];
      cyc(3);
    end
    cyc(6);
    tog[3] = ~tog[3];
    cyc(S + 1);
    chk("coinc_pulse", {31'd0, p0[3]}, 1);
    do_snap(1'b1);
    rd(2'd3);
    chk("clr_snap_ch3", {16'd0, rd0}, 7);

    rd_sel   = 2'd2;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    chk("rdsel_pre", {16'd0, rd0}, 20);
    @(negedge clk);
    chk("rdsel_post", {16'd0, rd0}, 0);
    rd(2'd3);
    chk("kept_inc_ch3", {16'd0, rd0}, 1);

    for (int k = 0; k < 9; k++) begin
      tog[0] = ~tog[0];
      cyc(3);
    end
    cyc(6);
    do_snap(1'b0);
    rd(2'd0);
    chk("pre_rst_ch0", {16'd0, rd0}, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", {16'd0, rd0}, 0);
    chk("mid_rst_valid", {31'd0, v0}, 0);
    chk("mid_rst_ready", {31'd0, r0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    do_snap(1'b0);
    rd(2'd0);
    chk("post_rst_ch0", {16'd0, rd0}, 0);
    chk("post_rst_valid", {31'd0, v0}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
